// File: rtl/kfx86_alu_result_stage.sv
// ALU result stage: 2-entry in-order writeback FIFO plus the architectural FLAGS register.
// Handles flag merge from the ALU, direct flag ops (CLC..STI) and POPF/IRET loads.
module kfx86_alu_result_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_result,
  input  logic [15:0] in_flags,
  input  logic [4:0]  in_opcode,
  input  logic        in_word,
  input  logic [2:0]  in_dest,
  input  logic        in_keep_carry,
  input  logic [2:0]  flag_op,
  input  logic        flags_load,
  input  logic [15:0] flags_load_data,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [15:0] wb_data,
  output logic [2:0]  wb_dest,
  output logic        wb_word,
  output logic        wb_enable,
  output logic [15:0] flags
);

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned FLAGS_W = 16;
  localparam int unsigned DEST_W  = 3;
  localparam int unsigned OP_W    = 5;
  localparam int unsigned FOP_W   = 3;
  localparam int unsigned CNT_W   = 2;

  localparam int unsigned BIT_C = 0;
  localparam int unsigned BIT_I = 9;
  localparam int unsigned BIT_D = 10;

  localparam logic [OP_W-1:0] OP_CMP = 5'b00111;

  localparam logic [FOP_W-1:0] FOP_CLC = 3'd1;
  localparam logic [FOP_W-1:0] FOP_STC = 3'd2;
  localparam logic [FOP_W-1:0] FOP_CMC = 3'd3;
  localparam logic [FOP_W-1:0] FOP_CLD = 3'd4;
  localparam logic [FOP_W-1:0] FOP_STD = 3'd5;
  localparam logic [FOP_W-1:0] FOP_CLI = 3'd6;
  localparam logic [FOP_W-1:0] FOP_STI = 3'd7;

  // O S Z A P come straight from the ALU; C is handled separately.
  localparam logic [FLAGS_W-1:0] ALU_MASK   = 16'h08D4;
  localparam logic [FLAGS_W-1:0] FORCE_ONE  = 16'hF002;
  localparam logic [FLAGS_W-1:0] FORCE_ZERO = 16'h0028;

  localparam logic [CNT_W-1:0] CNT_EMPTY = 2'd0;
  localparam logic [CNT_W-1:0] CNT_ONE   = 2'd1;
  localparam logic [CNT_W-1:0] CNT_FULL  = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DEST_W-1:0] dest;
    logic              word;
    logic              enable;
  } wb_entry_t;

  logic [CNT_W-1:0]   count_q, count_d;
  wb_entry_t          head_q, head_d, tail_q, tail_d, new_entry;
  logic [FLAGS_W-1:0] flags_q, flags_d, flags_work;
  logic               accept, pop;

  assign accept = in_valid && in_ready;
  assign pop    = wb_valid && wb_ready;

  assign new_entry = '{data:   in_result,
                       dest:   in_dest,
                       word:   in_word,
                       enable: (in_opcode != OP_CMP)};

  // FIFO: head is the oldest entry and drives wb_* directly.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case ({accept, pop})
      2'b10: begin
        if (count_q == CNT_EMPTY) head_d = new_entry;
        else                      tail_d = new_entry;
        count_d = count_q + CNT_ONE;
      end
      2'b01: begin
        if (count_q == CNT_FULL) head_d = tail_q;
        count_d = count_q - CNT_ONE;
      end
      2'b11: begin
        // accept implies count 1 here, so the new entry becomes the head
        head_d = new_entry;
      end
      default: ;
    endcase
  end

  // FLAGS: ALU merge, then direct flag op, then load override, then normalise.
  always_comb begin
    flags_work = flags_q;
    if (accept) begin
      flags_work = (flags_work & ~ALU_MASK) | (in_flags & ALU_MASK);
      if (!in_keep_carry) flags_work[BIT_C] = in_flags[BIT_C];
    end
    case (flag_op)
      FOP_CLC: flags_work[BIT_C] = 1'b0;
      FOP_STC: flags_work[BIT_C] = 1'b1;
      FOP_CMC: flags_work[BIT_C] = ~flags_work[BIT_C];
      FOP_CLD: flags_work[BIT_D] = 1'b0;
      FOP_STD: flags_work[BIT_D] = 1'b1;
      FOP_CLI: flags_work[BIT_I] = 1'b0;
      FOP_STI: flags_work[BIT_I] = 1'b1;
      default: ;
    endcase
    if (flags_load) flags_work = flags_load_data;
    flags_d = (flags_work | FORCE_ONE) & ~FORCE_ZERO;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q  <= CNT_EMPTY;
      head_q   <= '0;
      tail_q   <= '0;
      flags_q  <= FORCE_ONE;
      wb_valid <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      flags_q  <= flags_d;
      wb_valid <= (count_d != CNT_EMPTY);
      in_ready <= (count_d != CNT_FULL);
    end
  end

  assign wb_data   = head_q.data;
  assign wb_dest   = head_q.dest;
  assign wb_word   = head_q.word;
  assign wb_enable = head_q.enable;
  assign flags     = flags_q;

endmodule

// File: tb/tb_kfx86_alu_result_stage.sv
// Directed bench for kfx86_alu_result_stage: FIFO ordering, backpressure, flag merge and reset.
module tb_kfx86_alu_result_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_result = '0;
  logic [15:0] in_flags = '0;
  logic [4:0]  in_opcode = '0;
  logic        in_word = 1'b0;
  logic [2:0]  in_dest = '0;
  logic        in_keep_carry = 1'b0;
  logic [2:0]  flag_op = '0;
  logic        flags_load = 1'b0;
  logic [15:0] flags_load_data = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [15:0] wb_data;
  logic [2:0]  wb_dest;
  logic        wb_word;
  logic        wb_enable;
  logic [15:0] flags;

  int checks = 0;
  int errors = 0;

  kfx86_alu_result_stage dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_flags(in_flags), .in_opcode(in_opcode),
    .in_word(in_word), .in_dest(in_dest), .in_keep_carry(in_keep_carry),
    .flag_op(flag_op), .flags_load(flags_load), .flags_load_data(flags_load_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_dest(wb_dest), .wb_word(wb_word), .wb_enable(wb_enable),
    .flags(flags)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // one rising edge, then settle before sampling / driving
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [15:0] res, input logic [15:0] fl, input logic [4:0] op,
                       input logic word, input logic [2:0] dest, input logic keep);
    in_valid = 1'b1; in_result = res; in_flags = fl; in_opcode = op;
    in_word = word; in_dest = dest; in_keep_carry = keep;
  endtask

  initial begin
    // reset state
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rst_wb_valid", 32'(wb_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_flags", 32'(flags), 32'hF002);
    check("rst_wb_data", 32'(wb_data), 32'h0);
    check("rst_wb_enable", 32'(wb_enable), 32'h0);

    // ADD with flags C,P,Z
    wb_ready = 1'b1;
    drive(16'h0000, 16'h0045, 5'b00000, 1'b1, 3'd3, 1'b0);
    cyc();
    in_valid = 1'b0;
    check("add_wb_valid", 32'(wb_valid), 32'h1);
    check("add_wb_data", 32'(wb_data), 32'h0000);
    check("add_wb_enable", 32'(wb_enable), 32'h1);
    check("add_wb_dest", 32'(wb_dest), 32'h3);
    check("add_wb_word", 32'(wb_word), 32'h1);
    check("add_flags", 32'(flags), 32'hF047);
    cyc();
    check("add_drained", 32'(wb_valid), 32'h0);

    // backpressure and ordering
    wb_ready = 1'b0;
    drive(16'h1111, 16'h0000, 5'b00001, 1'b0, 3'd1, 1'b0);
    cyc();
    check("bp1_in_ready", 32'(in_ready), 32'h1);
    check("bp1_wb_data", 32'(wb_data), 32'h1111);
    drive(16'h2222, 16'h0000, 5'b00001, 1'b0, 3'd2, 1'b0);
    cyc();
    check("bp2_in_ready", 32'(in_ready), 32'h0);
    check("bp2_wb_data", 32'(wb_data), 32'h1111);
    drive(16'h3333, 16'h0000, 5'b00001, 1'b0, 3'd5, 1'b0);
    cyc();
    check("bp3_refused_ready", 32'(in_ready), 32'h0);
    check("bp3_stable_data", 32'(wb_data), 32'h1111);
    check("bp3_stable_dest", 32'(wb_dest), 32'h1);
    in_valid = 1'b0;
    wb_ready = 1'b1;
    cyc();
    check("pop1_wb_data", 32'(wb_data), 32'h2222);
    check("pop1_wb_valid", 32'(wb_valid), 32'h1);
    check("pop1_in_ready", 32'(in_ready), 32'h1);
    cyc();
    check("pop2_empty", 32'(wb_valid), 32'h0);

    // CMP: no register write, flags C,S,O
    drive(16'h5555, 16'h0881, 5'b00111, 1'b1, 3'd0, 1'b0);
    cyc();
    in_valid = 1'b0;
    check("cmp_wb_enable", 32'(wb_enable), 32'h0);
    check("cmp_wb_data", 32'(wb_data), 32'h5555);
    check("cmp_flags", 32'(flags), 32'hF883);

    // keep-carry retains C=1, then CMC on the same edge as another keep-carry accept
    drive(16'h0001, 16'h0000, 5'b00000, 1'b1, 3'd4, 1'b1);
    cyc();
    check("keepc_flags", 32'(flags), 32'hF003);
    flag_op = 3'd3;
    cyc();
    in_valid = 1'b0;
    flag_op = 3'd0;
    check("keepc_cmc_flags", 32'(flags), 32'hF002);

    // direct flag ops without an accept, then a load normalised
    flag_op = 3'd7;
    cyc();
    check("sti_flags", 32'(flags), 32'hF202);
    flag_op = 3'd5;
    cyc();
    check("std_flags", 32'(flags), 32'hF602);
    flag_op = 3'd0;
    flags_load = 1'b1;
    flags_load_data = 16'hFFFF;
    cyc();
    flags_load = 1'b0;
    check("load_norm_flags", 32'(flags), 32'hFFD7);
    check("drained_before_tid", 32'(wb_valid), 32'h0);

    // accept clears arithmetic flags but keeps T, I, D
    drive(16'h0042, 16'h0000, 5'b00110, 1'b0, 3'd6, 1'b0);
    cyc();
    in_valid = 1'b0;
    check("tid_kept_flags", 32'(flags), 32'hF702);
    cyc();

    // load overrides accept flags and STC, result still delivered
    drive(16'hABCD, 16'h08D5, 5'b00101, 1'b1, 3'd7, 1'b0);
    flag_op = 3'd2;
    flags_load = 1'b1;
    flags_load_data = 16'h0000;
    cyc();
    in_valid = 1'b0;
    flag_op = 3'd0;
    flags_load = 1'b0;
    check("load_ovr_flags", 32'(flags), 32'hF002);
    check("load_ovr_wb_valid", 32'(wb_valid), 32'h1);
    check("load_ovr_wb_data", 32'(wb_data), 32'hABCD);
    cyc();

    // fill to two, then reset mid-operation with competing activity
    wb_ready = 1'b0;
    drive(16'h7777, 16'h0001, 5'b00000, 1'b1, 3'd1, 1'b0);
    cyc();
    drive(16'h8888, 16'h0001, 5'b00000, 1'b1, 3'd2, 1'b0);
    cyc();
    check("full_in_ready", 32'(in_ready), 32'h0);
    reset = 1'b1;
    wb_ready = 1'b1;
    flag_op = 3'd2;
    flags_load = 1'b1;
    flags_load_data = 16'h0FFF;
    cyc();
    reset = 1'b0;
    in_valid = 1'b0;
    flag_op = 3'd0;
    flags_load = 1'b0;
    check("rst2_wb_valid", 32'(wb_valid), 32'h0);
    check("rst2_flags", 32'(flags), 32'hF002);
    check("rst2_in_ready", 32'(in_ready), 32'h1);
    check("rst2_wb_data", 32'(wb_data), 32'h0);
    cyc();
    check("rst2_still_empty", 32'(wb_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
